// File: rtl/kbd_pkg.sv
// Shared definitions for the key debouncer: per-key FSM states and default timing.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } kbd_state_t;

  localparam int DEF_NUM_KEYS     = 4;
  localparam int DEF_ACTIVE_LOW   = 1;
  localparam int DEF_STABLE_TICKS = 4;
  localparam int DEF_LONG_TICKS   = 50;
  localparam int DEF_REPEAT_TICKS = 10;

  // Bits needed to hold values 0..max_count without wrapping.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM, hold/repeat counter, registered pulses.
module key_debounce_ch
  import kbd_pkg::*;
#(
  parameter int ACTIVE_LOW   = DEF_ACTIVE_LOW,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic key_raw,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam int CW = cnt_width(STABLE_TICKS);
  localparam int HW = cnt_width(LONG_TICKS + REPEAT_TICKS);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_TICKS - 1);
  // After the first repeat the hold counter cycles REP_BASE..REP_LAST.
  localparam logic [HW-1:0] REP_BASE    = HW'(LONG_TICKS);
  localparam logic [HW-1:0] REP_LAST    = HW'(LONG_TICKS + REPEAT_TICKS - 1);
  localparam logic          IDLE_LVL    = (ACTIVE_LOW != 0);

  logic            sync1_reg, sync2_reg;
  logic            s;
  kbd_state_t      state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [HW-1:0]   hold_reg;
  logic            state_out_reg, press_reg, release_reg, repeat_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= IDLE_LVL;
      sync2_reg <= IDLE_LVL;
    end else begin
      sync1_reg <= key_raw;
      sync2_reg <= sync1_reg;
    end
  end

  assign s = (ACTIVE_LOW != 0) ? ~sync2_reg : sync2_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      hold_reg      <= '0;
      state_out_reg <= 1'b0;
      press_reg     <= 1'b0;
      release_reg   <= 1'b0;
      repeat_reg    <= 1'b0;
    end else begin
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      repeat_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (s) begin
            state_reg <= PRESS_WAIT;
            cnt_reg   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_reg <= IDLE;
          end else if (tick) begin
            if (cnt_reg == STABLE_LAST) begin
              state_reg     <= HELD;
              state_out_reg <= 1'b1;
              press_reg     <= 1'b1;
              hold_reg      <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        HELD: begin
          if (!s) begin
            state_reg <= RELEASE_WAIT;
            cnt_reg   <= '0;
          end else if (tick) begin
            // With repeat disabled the counter simply parks at LONG_LAST.
            if (hold_reg == LONG_LAST) begin
              if (REPEAT_TICKS != 0) begin
                repeat_reg <= 1'b1;
                hold_reg   <= REP_BASE;
              end
            end else if ((REPEAT_TICKS != 0) && (hold_reg == REP_LAST)) begin
              repeat_reg <= 1'b1;
              hold_reg   <= REP_BASE;
            end else begin
              hold_reg <= hold_reg + 1'b1;
            end
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state_reg <= HELD;
          end else if (tick) begin
            if (cnt_reg == STABLE_LAST) begin
              state_reg     <= IDLE;
              state_out_reg <= 1'b0;
              release_reg   <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign key_state   = state_out_reg;
  assign key_press   = press_reg;
  assign key_release = release_reg;
  assign key_repeat  = repeat_reg;

endmodule

// File: rtl/key_debouncer.sv
// Multi-key debouncer: NUM_KEYS independent channels timed by an external tick strobe.
module key_debouncer
  import kbd_pkg::*;
#(
  parameter int NUM_KEYS     = DEF_NUM_KEYS,
  parameter int ACTIVE_LOW   = DEF_ACTIVE_LOW,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat
);

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce_ch #(
        .ACTIVE_LOW  (ACTIVE_LOW),
        .STABLE_TICKS(STABLE_TICKS),
        .LONG_TICKS  (LONG_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS)
      ) u_ch (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .key_raw    (key_raw[gi]),
        .key_state  (key_state[gi]),
        .key_press  (key_press[gi]),
        .key_release(key_release[gi]),
        .key_repeat (key_repeat[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with an event scoreboard; a second instance runs with repeat disabled.
module tb_key_debouncer;

  localparam int NK   = 2;
  localparam int LONG = 8;
  localparam int REP  = 3;

  typedef struct {
    int kind;     // 0 press, 1 release, 2 repeat
    int key;
    int tick_at;  // expected tick count at the pulse, -1 = don't care
  } ev_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] key_state, key_press, key_release, key_repeat;
  logic [NK-1:0] st0, pr0, rl0, rp0;

  ev_t exp_q[$];
  int  passed_cnt = 0;
  int  total_cnt  = 0;
  int  tick_cnt   = 0;
  int  div        = 0;
  bit  tick_high  = 0;
  int  rep0_cnt   = 0;
  int  rep_cnt   [NK];
  int  rel_cnt   [NK];
  bit  press_seen[NK];
  int  press_tick[NK];
  time press_time[NK];

  key_debouncer #(.NUM_KEYS(NK), .ACTIVE_LOW(1), .STABLE_TICKS(4),
                  .LONG_TICKS(LONG), .REPEAT_TICKS(REP)) dut (
    .clk(clk), .reset(reset), .tick(tick), .key_raw(key_raw),
    .key_state(key_state), .key_press(key_press),
    .key_release(key_release), .key_repeat(key_repeat));

  key_debouncer #(.NUM_KEYS(NK), .ACTIVE_LOW(1), .STABLE_TICKS(4),
                  .LONG_TICKS(LONG), .REPEAT_TICKS(0)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .key_raw(key_raw),
    .key_state(st0), .key_press(pr0),
    .key_release(rl0), .key_repeat(rp0));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    total_cnt++;
    assert (obs === exp_v) passed_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
  endtask

  task automatic match_event(input int kind, input int k);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event(key*10+kind)", k * 10 + kind, -1);
    end else begin
      e = exp_q.pop_front();
      check("event_id(key*10+kind)", k * 10 + kind, e.key * 10 + e.kind);
      if (e.tick_at >= 0) check("event_tick", tick_cnt, e.tick_at);
    end
  endtask

  task automatic monitor();
    logic [2:0] pv;
    if (reset) return;
    for (int k = 0; k < NK; k++) begin
      if (rp0[k]) rep0_cnt++;
      if (key_press[k]) begin
        press_seen[k] = 1;
        press_tick[k] = tick_cnt;
        press_time[k] = $time;
      end
      if (key_repeat[k])  rep_cnt[k]++;
      if (key_release[k]) rel_cnt[k]++;
      pv = {key_repeat[k], key_release[k], key_press[k]};
      for (int kind = 0; kind < 3; kind++)
        if (pv[kind]) match_event(kind, k);
    end
  endtask

  // Tick strobe (1-of-5 clk, or permanently high) plus the output monitor, both at negedge.
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick) tick_cnt++;
      monitor();
      div  = (div == 4) ? 0 : div + 1;
      tick = tick_high || (div == 4);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_press(input int k, input int hold_ticks);
    int t0, p, lat;
    bit got;
    t0 = tick_cnt;
    press_seen[k] = 0;
    exp_q.push_back('{0, k, -1});
    key_raw[k] = 1'b0;
    got = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      step();
      got = press_seen[k];
    end
    check($sformatf("press_seen_key%0d", k), int'(got), 1);
    lat = press_tick[k] - t0;
    if (!tick_high)
      check($sformatf("press_latency=%0d_in_4..5", lat), int'(lat >= 4 && lat <= 5), 1);
    p = press_tick[k];
    for (int h = LONG; h <= hold_ticks; h += REP) exp_q.push_back('{2, k, p + h});
    for (int i = 0; i < 400 && tick_cnt < p + hold_ticks; i++) step();
  endtask

  task automatic expect_release(input logic [NK-1:0] mask);
    for (int k = 0; k < NK; k++)
      if (mask[k]) begin
        exp_q.push_back('{1, k, -1});
        key_raw[k] = 1'b1;
      end
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) step();
    check("release_queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, rp;
    for (int k = 0; k < NK; k++) begin
      rep_cnt[k] = 0; rel_cnt[k] = 0; press_seen[k] = 0;
      press_tick[k] = 0; press_time[k] = 0;
    end
    reset   = 1'b1;
    key_raw = 2'b11;
    repeat (4) step();
    check("reset_outputs", int'({key_state, key_press, key_release, key_repeat}), 0);
    reset = 1'b0;
    repeat (10) step();
    check("idle_state", int'(key_state), 0);

    // Clean press, held ~20 ticks (repeats at hold ticks 8,11,14,17,20).
    expect_press(0, 20);
    check("clean_press_state", int'(key_state), 1);
    check("clean_press_queue", exp_q.size(), 0);
    expect_release(2'b01);
    check("clean_release_state", int'(key_state), 0);

    // Bounce: toggle every 3 clk for ~40 clk, ends inactive, then stable press.
    for (int i = 0; i < 14; i++) begin
      key_raw[0] = ~key_raw[0];
      repeat (3) step();
    end
    check("bounce_no_press_state", int'(key_state), 0);
    expect_press(0, 2);

    // Release glitch of 2 ticks must not release.
    r0 = rel_cnt[0];
    key_raw[0] = 1'b1;
    repeat (10) step();
    key_raw[0] = 1'b0;
    repeat (6) step();
    check("glitch_no_release", rel_cnt[0] - r0, 0);
    check("glitch_state_held", int'(key_state), 1);
    expect_release(2'b01);
    check("glitch_then_release", rel_cnt[0] - r0, 1);
    check("after_release_state", int'(key_state), 0);

    // Auto-repeat over 30 hold ticks.
    rp = rep_cnt[0];
    expect_press(0, 30);
    check("repeat_count", rep_cnt[0] - rp, 8);
    expect_release(2'b01);
    check("repeat_disabled_count", rep0_cnt, 0);

    // Reset mid-hold on key 1.
    expect_press(1, 3);
    check("hold_before_reset", int'(key_state), 2);
    reset = 1'b1;
    step();
    check("reset_mid_hold_outputs", int'({key_state, key_press, key_release, key_repeat}), 0);
    reset = 1'b0;
    expect_press(1, 2);
    check("fresh_press_state", int'(key_state), 2);
    expect_release(2'b10);

    // Tick tied high, both keys pressed in the same clk.
    tick_high = 1;
    repeat (3) step();
    press_seen[0] = 0;
    press_seen[1] = 0;
    exp_q.push_back('{0, 0, -1});
    exp_q.push_back('{0, 1, -1});
    key_raw = 2'b00;
    for (int i = 0; i < 20 && !(press_seen[0] && press_seen[1]); i++) step();
    check("dual_press_seen", int'(press_seen[0] && press_seen[1]), 1);
    check("dual_press_same_clk", int'(press_time[0] == press_time[1]), 1);
    check("dual_press_state", int'(key_state), 3);
    expect_release(2'b11);
    check("dual_release_state", int'(key_state), 0);

    repeat (5) step();
    check("final_queue_empty", exp_q.size(), 0);
    check("final_repeat_disabled", rep0_cnt, 0);
    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end

endmodule
